// File: rtl/spart_baud_gen_if.sv
// SPART I/O bus bundle as seen by the baud-rate generator.
// master : processor side, drives iocs/iorw/ioaddr/data and observes the ticks.
// slave  : baud generator side, samples the bus and drives sample_en/enable/running.
//   iocs      chip select
//   iorw      1 = read, 0 = write
//   ioaddr    register select (2'b10 DB low, 2'b11 DB high)
//   data      write data
//   sample_en 16x oversample tick
//   enable    one-per-bit tick
//   running   committed divisor non-zero, ticks active
interface spart_baud_gen_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] data;
    logic       sample_en;
    logic       enable;
    logic       running;

    modport master (
        output iocs, iorw, ioaddr, data,
        input  sample_en, enable, running
    );

    modport slave (
        input  iocs, iorw, ioaddr, data,
        output sample_en, enable, running
    );
endinterface

// File: rtl/spart_baud_gen.sv
// Baud-rate generator for the SPART. A programmable 16-bit divisor sets the
// sample_en period in clocks; enable fires on every 16th sample_en.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  spart_baud_gen_if.slave (bus write decode in, tick outputs out)
//
// state | meaning
// ------+-----------------------------------------------
// HOLD  | divisor is zero, counters frozen, no ticks
// RUN   | counting down, ticks emitted on cnt == 0
module spart_baud_gen #(
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic              clk,
    input  logic              rst,
    spart_baud_gen_if.slave   bus
);

    typedef enum logic {HOLD, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  db_lo_q, db_lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  tick_q, tick_d;
    logic        sample_en_q, sample_en_d;
    logic        enable_q, enable_d;
    logic        running_q, running_d;

    logic        wr;
    logic        wr_lo;
    logic        wr_hi;
    logic [15:0] new_div;

    assign wr      = bus.iocs & ~bus.iorw;
    assign wr_lo   = wr & (bus.ioaddr == 2'b10);
    assign wr_hi   = wr & (bus.ioaddr == 2'b11);
    assign new_div = {bus.data, db_lo_q};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        db_lo_d     = db_lo_q;
        cnt_d       = cnt_q;
        tick_d      = tick_q;
        sample_en_d = 1'b0;
        enable_d    = 1'b0;

        if (wr_lo) begin
            db_lo_d = bus.data;
        end

        // A high-byte commit overrides any tick due this cycle.
        if (wr_hi) begin
            div_d   = new_div;
            cnt_d   = new_div - 16'd1;
            tick_d  = 4'd0;
            state_d = (new_div != 16'd0) ? RUN : HOLD;
        end else if (state_q == RUN) begin
            if (cnt_q == 16'd0) begin
                sample_en_d = 1'b1;
                enable_d    = (tick_q == 4'hF);
                cnt_d       = div_q - 16'd1;
                tick_d      = tick_q + 4'd1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (DEFAULT_DIV != 16'd0) ? RUN : HOLD;
            div_q       <= DEFAULT_DIV;
            db_lo_q     <= DEFAULT_DIV[7:0];
            cnt_q       <= DEFAULT_DIV - 16'd1;
            tick_q      <= 4'd0;
            sample_en_q <= 1'b0;
            enable_q    <= 1'b0;
            running_q   <= (DEFAULT_DIV != 16'd0);
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            db_lo_q     <= db_lo_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            sample_en_q <= sample_en_d;
            enable_q    <= enable_d;
            running_q   <= running_d;
        end
    end

    assign bus.sample_en = sample_en_q;
    assign bus.enable    = enable_q;
    assign bus.running   = running_q;

endmodule

// File: tb/tb_spart_baud_gen.sv
// Scoreboard bench for spart_baud_gen (DEFAULT_DIV = 4). The stimulus process
// pushes the edge numbers at which sample_en / enable must appear; a monitor
// on the falling edge pops and compares whenever a pulse shows up, and flags
// any expected pulse whose edge has passed without one.
module tb_spart_baud_gen;

    logic clk;
    logic rst;
    int   edge_n;
    int   checks;
    int   errors;
    int   exp_se[$];
    int   exp_en[$];

    spart_baud_gen_if bif();

    spart_baud_gen #(.DEFAULT_DIV(16'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge 1 is the first rising edge with rst low.
    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    always @(negedge clk) begin
        if (bif.sample_en) begin
            checks++;
            if (exp_se.size() == 0) begin
                errors++;
                $display("FAIL sample_en_unexpected: pulse at edge %0d, none required", edge_n);
            end else begin
                int e;
                e = exp_se.pop_front();
                if (e != edge_n) begin
                    errors++;
                    $display("FAIL sample_en_edge: pulse at edge %0d, required edge %0d", edge_n, e);
                end
            end
        end
        while (exp_se.size() > 0 && exp_se[0] < edge_n) begin
            checks++;
            errors++;
            $display("FAIL sample_en_missing: no pulse by edge %0d, required at edge %0d", edge_n, exp_se[0]);
            void'(exp_se.pop_front());
        end

        if (bif.enable) begin
            checks++;
            if (exp_en.size() == 0) begin
                errors++;
                $display("FAIL enable_unexpected: pulse at edge %0d, none required", edge_n);
            end else begin
                int e;
                e = exp_en.pop_front();
                if (e != edge_n) begin
                    errors++;
                    $display("FAIL enable_edge: pulse at edge %0d, required edge %0d", edge_n, e);
                end
            end
        end
        while (exp_en.size() > 0 && exp_en[0] < edge_n) begin
            checks++;
            errors++;
            $display("FAIL enable_missing: no pulse by edge %0d, required at edge %0d", edge_n, exp_en[0]);
            void'(exp_en.pop_front());
        end
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Expected pulses for divisor d committed at edge w, up to (not including) edge stop.
    task automatic push_run(input int w, input int d, input int stop);
        if (d > 0) begin
            for (int k = 1; w + k * d < stop; k++) begin
                exp_se.push_back(w + k * d);
                if (k % 16 == 0) exp_en.push_back(w + k * d);
            end
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    // Called on a falling edge; the cycle is sampled at the next rising edge.
    task automatic bus_cycle(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        bif.iocs   = cs;
        bif.iorw   = rw;
        bif.ioaddr = a;
        bif.data   = d;
        @(negedge clk);
        bif.iocs   = 1'b0;
        bif.iorw   = 1'b1;
        bif.ioaddr = 2'b00;
        bif.data   = 8'h00;
    endtask

    task automatic at_edge(input int n, input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        wait_edge(n - 1);
        bus_cycle(cs, rw, a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bif.iocs   = 1'b0;
        bif.iorw   = 1'b1;
        bif.ioaddr = 2'b00;
        bif.data   = 8'h00;
        repeat (3) @(negedge clk);
        check_bit("reset_sample_en", bif.sample_en, 1'b0);
        check_bit("reset_enable", bif.enable, 1'b0);
        check_bit("reset_running", bif.running, 1'b1);

        // Default divisor 4: sample_en after 4,8,...; enable after 64,128.
        push_run(0, 4, 150);
        rst = 1'b0;
        at_edge(140, 1'b1, 1'b0, 2'b10, 8'h02);   // DB low on a tick edge
        at_edge(150, 1'b1, 1'b0, 2'b11, 8'h00);   // commit 2
        check_bit("running_div2", bif.running, 1'b1);

        // Divisor 2, with non-commit bus cycles on DB high that must be ignored.
        push_run(150, 2, 230);
        at_edge(200, 1'b1, 1'b0, 2'b10, 8'h07);   // stage 7
        at_edge(204, 1'b1, 1'b1, 2'b11, 8'h00);   // read
        at_edge(206, 1'b0, 1'b0, 2'b11, 8'h00);   // not selected
        at_edge(208, 1'b1, 1'b0, 2'b00, 8'h00);   // other register
        at_edge(210, 1'b1, 1'b0, 2'b01, 8'h00);   // other register
        // Commit 7 on an edge where a divisor-2 tick is due: write wins.
        at_edge(230, 1'b1, 1'b0, 2'b11, 8'h00);
        check_bit("no_pulse_on_commit", bif.sample_en, 1'b0);

        push_run(230, 7, 360);
        at_edge(350, 1'b1, 1'b0, 2'b10, 8'h00);
        at_edge(360, 1'b1, 1'b0, 2'b11, 8'h00);   // commit 0 -> HOLD
        check_bit("running_div0", bif.running, 1'b0);
        wait_edge(1360);
        check_bit("running_hold_1000", bif.running, 1'b0);

        at_edge(1365, 1'b1, 1'b0, 2'b10, 8'h03);
        at_edge(1370, 1'b1, 1'b0, 2'b11, 8'h00);  // commit 3
        check_bit("running_div3", bif.running, 1'b1);
        push_run(1370, 3, 1480);

        at_edge(1475, 1'b1, 1'b0, 2'b10, 8'h05);
        at_edge(1480, 1'b1, 1'b0, 2'b11, 8'h00);  // commit 5
        push_run(1480, 5, 1520);

        // Reset sampled at edge 1520, where a tick was due: it is dropped.
        wait_edge(1519);
        rst = 1'b1;
        @(negedge clk);
        check_bit("midrst_sample_en", bif.sample_en, 1'b0);
        check_bit("midrst_enable", bif.enable, 1'b0);
        check_bit("midrst_running", bif.running, 1'b1);
        rst = 1'b0;
        push_run(0, 4, 141);
        wait_edge(141);

        checks++;
        if (exp_se.size() != 0 || exp_en.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: %0d sample_en and %0d enable pulses outstanding, required 0",
                     exp_se.size(), exp_en.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
